mem_port_arbiter: RTL and testbench

- Shares one external memory port between the I-cache and D-cache miss/writeback interfaces.
- Lets the CPU top drive a single-channel memory controller instead of the current dual-channel bus.
- Sits between the caches' memory-side ports and the memory controller.
- Uses the same rw_flag/busy/done protocol on both sides: upstream it looks like memory, downstream it looks like one cache.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-cache and D-cache requesters; MEM_ARB_PERF_EN adds perf counters.
// One cycle from request to mem_rw_flag, one RELEASE cycle after done; busy whenever not IDLE or memory busy.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              i_rw_flag,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wmask,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_busy,
  output logic                    i_done,
  input  logic [1:0]              d_rw_flag,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_busy,
  output logic                    d_done,
  output logic [1:0]              mem_rw_flag,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic [DATA_WIDTH/8-1:0] mem_write_mask,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  input  logic                    mem_busy,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]             perf_i_grants,
  output logic [31:0]             perf_d_grants,
  output logic [31:0]             perf_i_wait,
`endif
  input  logic                    mem_done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GNT_I   = 2'd1;
  localparam logic [1:0] S_GNT_D   = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic [3:0] starve_cnt;
  logic       i_req_vld;
  logic       d_req_vld;
  logic       grant;
  logic       pick_i;

  // 2'b11 is deliberately excluded so it can never be forwarded downstream
  assign i_req_vld = (i_rw_flag == 2'b01) || (i_rw_flag == 2'b10);
  assign d_req_vld = (d_rw_flag == 2'b01) || (d_rw_flag == 2'b10);

  assign grant  = (state == S_IDLE) && !mem_busy && (i_req_vld || d_req_vld);
  assign pick_i = i_req_vld && (!d_req_vld || (starve_cnt == LIMIT));

  assign i_busy = (state != S_IDLE) || mem_busy;
  assign d_busy = (state != S_IDLE) || mem_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      mem_rw_flag    <= 2'b00;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_write_mask <= '0;
      i_rdata        <= '0;
      d_rdata        <= '0;
      i_done         <= 1'b0;
      d_done         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            if (pick_i) begin
              mem_rw_flag    <= i_rw_flag;
              mem_addr       <= i_addr;
              mem_write_data <= i_wdata;
              mem_write_mask <= i_wmask;
              state          <= S_GNT_I;
            end else begin
              mem_rw_flag    <= d_rw_flag;
              mem_addr       <= d_addr;
              mem_write_data <= d_wdata;
              mem_write_mask <= d_wmask;
              state          <= S_GNT_D;
            end
          end
        end
        S_GNT_I: begin
          if (mem_done) begin
            i_rdata     <= mem_read_data;
            i_done      <= 1'b1;
            mem_rw_flag <= 2'b00;
            state       <= S_RELEASE;
          end
        end
        S_GNT_D: begin
          if (mem_done) begin
            d_rdata     <= mem_read_data;
            d_done      <= 1'b1;
            mem_rw_flag <= 2'b00;
            state       <= S_RELEASE;
          end
        end
        default: begin
          // Finishing requester still holds its flag here; skipping arbitration avoids a re-grant.
          i_done <= 1'b0;
          d_done <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= 4'd0;
    end else if (grant && pick_i) begin
      starve_cnt <= 4'd0;
    end else if (grant && i_req_vld) begin
      if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else if ((state == S_IDLE) && !i_req_vld) begin
      starve_cnt <= 4'd0;
    end
  end

`ifdef MEM_ARB_PERF_EN
  // i_done is high only in the RELEASE cycle that follows an I transaction
  logic i_served;
  assign i_served = (state == S_GNT_I) || i_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_i_grants <= 32'd0;
      perf_d_grants <= 32'd0;
      perf_i_wait   <= 32'd0;
    end else begin
      if (grant && pick_i) begin
        perf_i_grants <= perf_i_grants + 32'd1;
      end
      if (grant && !pick_i) begin
        perf_d_grants <= perf_d_grants + 32'd1;
      end
      if (i_req_vld && !i_served) begin
        perf_i_wait <= perf_i_wait + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int LIMIT = 2;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] i_rw_flag, d_rw_flag;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata;
  logic [MW-1:0] i_wmask, d_wmask;
  logic [DW-1:0] i_rdata, d_rdata;
  logic i_busy, i_done, d_busy, d_done;
  logic [1:0] mem_rw_flag;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic [MW-1:0] mem_write_mask;
  logic mem_busy, mem_done;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_grants, perf_d_grants, perf_i_wait;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_rw_flag(i_rw_flag), .i_addr(i_addr), .i_wdata(i_wdata), .i_wmask(i_wmask),
    .i_rdata(i_rdata), .i_busy(i_busy), .i_done(i_done),
    .d_rw_flag(d_rw_flag), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata), .d_busy(d_busy), .d_done(d_done),
    .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write_mask(mem_write_mask), .mem_read_data(mem_read_data), .mem_busy(mem_busy),
`ifdef MEM_ARB_PERF_EN
    .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants), .perf_i_wait(perf_i_wait),
`endif
    .mem_done(mem_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int          m_owner;    // 0 none, 1 I, 2 D
  bit          m_rel;
  int          m_rel_who;
  int          m_streak;   // consecutive D wins while I was waiting
  logic [1:0]  e_flag;
  logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
  logic [3:0]  e_mask;
  logic        e_idone, e_ddone;
  logic [31:0] m_ig, m_dg, m_iw;

  function automatic void model_reset();
    m_owner = 0; m_rel = 0; m_rel_who = 0; m_streak = 0;
    e_flag = 2'b00; e_addr = '0; e_wdata = '0; e_mask = '0;
    e_irdata = '0; e_drdata = '0; e_idone = 1'b0; e_ddone = 1'b0;
    m_ig = '0; m_dg = '0; m_iw = '0;
  endfunction

  initial begin : model
    bit iv, dv, mb, md, take_i;
    logic [1:0] fi, fd;
    logic [31:0] ai, ad, wi, wd, rd;
    logic [3:0] ki, kd;
    model_reset();
    forever begin
      @(posedge clk);
      iv = (i_rw_flag == 2'b01) || (i_rw_flag == 2'b10);
      dv = (d_rw_flag == 2'b01) || (d_rw_flag == 2'b10);
      fi = i_rw_flag; ai = i_addr; wi = i_wdata; ki = i_wmask;
      fd = d_rw_flag; ad = d_addr; wd = d_wdata; kd = d_wmask;
      mb = mem_busy; md = mem_done; rd = mem_read_data;
      if (!rst) begin
        model_reset();
      end else begin
        if (iv && !(m_owner == 1 || (m_rel && m_rel_who == 1))) m_iw++;
        if (m_rel) begin
          m_rel = 0; e_idone = 1'b0; e_ddone = 1'b0;
        end else if (m_owner != 0) begin
          if (md) begin
            if (m_owner == 1) begin e_irdata = rd; e_idone = 1'b1; end
            else begin e_drdata = rd; e_ddone = 1'b1; end
            e_flag = 2'b00; m_rel = 1; m_rel_who = m_owner; m_owner = 0;
          end
        end else if (!mb && (iv || dv)) begin
          take_i = iv && (!dv || m_streak >= LIMIT);
          if (take_i) begin
            m_owner = 1; e_flag = fi; e_addr = ai; e_wdata = wi; e_mask = ki;
            m_streak = 0; m_ig++;
          end else begin
            m_owner = 2; e_flag = fd; e_addr = ad; e_wdata = wd; e_mask = kd;
            m_dg++;
            m_streak = iv ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
          end
        end else if (!iv) begin
          m_streak = 0;
        end
      end
      #1;
      check("mem_rw_flag", mem_rw_flag, e_flag);
      check("mem_addr", mem_addr, e_addr);
      check("mem_write_data", mem_write_data, e_wdata);
      check("mem_write_mask", mem_write_mask, e_mask);
      check("i_rdata", i_rdata, e_irdata);
      check("d_rdata", d_rdata, e_drdata);
      check("i_done", i_done, e_idone);
      check("d_done", d_done, e_ddone);
      check("i_busy", i_busy, (m_owner != 0 || m_rel || mem_busy));
      check("d_busy", d_busy, (m_owner != 0 || m_rel || mem_busy));
`ifdef MEM_ARB_PERF_EN
      check("perf_i_grants", perf_i_grants, m_ig);
      check("perf_d_grants", perf_d_grants, m_dg);
      check("perf_i_wait", perf_i_wait, m_iw);
`endif
    end
  end

  // ---------------- stimulus: requesters and memory responder ----------------
  int cyc = 0;
  bit inflight = 0;
  int cnt = 0;
  int lat_fixed = 1;
  bit rdata_fixed_en = 0;
  logic [31:0] rdata_fixed = '0;
  bit spurious_en = 0, rand_busy = 0, rand_req = 0, hold_req = 0;
  bit i_pend = 0, d_pend = 0;
  logic [1:0] prev_flag = 2'b00;
  logic [31:0] gq[$];
  logic [1:0]  gflag[$];
  logic [31:0] gdata[$];
  int          gcyc[$];
  int i_done_n, d_done_n, i_done_cyc, d_done_cyc;
  logic [31:0] i_rd;

  task automatic clear_logs();
    gq.delete(); gflag.delete(); gdata.delete(); gcyc.delete();
    i_done_n = 0; d_done_n = 0; i_done_cyc = 0; d_done_cyc = 0; i_rd = '0;
  endtask

  task automatic tick();
    int r;
    @(negedge clk);
    cyc++;
    mem_done = 1'b0;
    if (mem_rw_flag != 2'b00) begin
      if (!inflight) begin
        inflight = 1;
        cnt = ((lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4))) - 1;
      end
      if (cnt == 0) begin
        mem_done = 1'b1;
        mem_read_data = rdata_fixed_en ? rdata_fixed : $urandom;
      end else begin
        cnt--;
      end
    end else begin
      inflight = 0;
      if (spurious_en && $urandom_range(0, 7) == 0) begin
        mem_done = 1'b1;
        mem_read_data = $urandom;
      end
    end
    if (rand_busy) mem_busy = ($urandom_range(0, 3) == 0);
    if (mem_rw_flag != 2'b00 && prev_flag == 2'b00) begin
      gq.push_back(mem_addr); gflag.push_back(mem_rw_flag);
      gdata.push_back(mem_write_data); gcyc.push_back(cyc);
    end
    prev_flag = mem_rw_flag;
    if (i_done) begin i_done_n++; i_rd = i_rdata; i_done_cyc = cyc; end
    if (d_done) begin d_done_n++; d_done_cyc = cyc; end
    if (rand_req) begin
      if (i_done || !i_pend) begin
        r = int'($urandom_range(0, 5));
        i_pend = (r < 2);
        i_rw_flag = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 5) ? 2'b11 : 2'b00;
        i_addr = $urandom; i_wdata = $urandom; i_wmask = 4'($urandom);
      end
      if (d_done || !d_pend) begin
        r = int'($urandom_range(0, 4));
        d_pend = (r < 2);
        d_rw_flag = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 4) ? 2'b11 : 2'b00;
        d_addr = $urandom; d_wdata = $urandom; d_wmask = 4'($urandom);
      end
    end else if (!hold_req) begin
      if (i_done) i_rw_flag = 2'b00;
      if (d_done) d_rw_flag = 2'b00;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [3:0] exp_seq [6];
    rst = 1'b0;
    i_rw_flag = 2'b00; i_addr = '0; i_wdata = '0; i_wmask = '0;
    d_rw_flag = 2'b00; d_addr = '0; d_wdata = '0; d_wmask = '0;
    mem_read_data = '0; mem_busy = 1'b0; mem_done = 1'b0;
    clear_logs();
    run(3);
    check("reset_mem_flag", mem_rw_flag, 2'b00);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_dones", {i_done, d_done}, 2'b00);
    check("reset_rdata", {i_rdata, d_rdata}, 64'h0);
    check("reset_busy", i_busy, 1'b0);
    rst = 1'b1;
    run(2);

    // single I read, memory answers 3 cycles after the grant
    clear_logs();
    lat_fixed = 3; rdata_fixed_en = 1; rdata_fixed = 32'hDEADBEEF;
    i_rw_flag = 2'b01; i_addr = 32'h100;
    run(12);
    check("t1_grants", gq.size(), 1);
    check("t1_addr", (gq.size() > 0) ? gq[0] : 32'hFFFF_FFFF, 32'h100);
    check("t1_flag", (gflag.size() > 0) ? gflag[0] : 2'b11, 2'b01);
    check("t1_done_cycles", i_done_n, 1);
    check("t1_rdata", i_rd, 32'hDEADBEEF);
    check("t1_done_latency", (gcyc.size() > 0) ? i_done_cyc - gcyc[0] : -1, 3);
    check("t1_d_done", d_done_n, 0);
    rdata_fixed_en = 0;

    // simultaneous I read and D write: D first, I right after RELEASE
    clear_logs();
    lat_fixed = 2;
    i_rw_flag = 2'b01; i_addr = 32'h200;
    d_rw_flag = 2'b10; d_addr = 32'h300; d_wdata = 32'h12345678; d_wmask = 4'hF;
    run(20);
    check("t2_grants", gq.size(), 2);
    check("t2_first_addr", (gq.size() > 0) ? gq[0] : 32'hFFFF_FFFF, 32'h300);
    check("t2_first_flag", (gflag.size() > 0) ? gflag[0] : 2'b11, 2'b10);
    check("t2_first_wdata", (gdata.size() > 0) ? gdata[0] : 32'hFFFF_FFFF, 32'h12345678);
    check("t2_second_addr", (gq.size() > 1) ? gq[1] : 32'hFFFF_FFFF, 32'h200);
    check("t2_second_after_release", (gcyc.size() > 1) ? gcyc[1] - d_done_cyc : -1, 2);
    check("t2_dones", {i_done_n[7:0], d_done_n[7:0]}, 16'h0101);

    // starvation with limit 2: both sides re-request continuously
    clear_logs();
    lat_fixed = 1; hold_req = 1;
    i_rw_flag = 2'b01; i_addr = 32'hA00;
    d_rw_flag = 2'b10; d_addr = 32'hB00;
    for (int k = 0; k < 100 && gq.size() < 6; k++) tick();
    hold_req = 0;
    run(20);
    exp_seq = '{4'hB, 4'hB, 4'hA, 4'hB, 4'hB, 4'hA};
    check("t3_grant_count", (gq.size() >= 6) ? 6 : gq.size(), 6);
    for (int k = 0; k < 6; k++)
      check($sformatf("t3_order_%0d", k), (gq.size() > k) ? gq[k][11:8] : 4'h0, exp_seq[k]);

    // memory busy for 5 cycles holds off a pending D request
    clear_logs();
    i_rw_flag = 2'b00; d_rw_flag = 2'b00;
    mem_busy = 1'b1;
    d_rw_flag = 2'b01; d_addr = 32'h400;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t4_held_%0d", k), mem_rw_flag, 2'b00);
    end
    mem_busy = 1'b0;
    tick();
    check("t4_grant_flag", mem_rw_flag, 2'b01);
    check("t4_grant_addr", mem_addr, 32'h400);
    run(10);

    // reset in the middle of a D write, then the held request is re-granted
    clear_logs();
    lat_fixed = 20;
    d_rw_flag = 2'b10; d_addr = 32'h300; d_wdata = 32'hCAFE0001;
    tick();
    check("t5_granted", mem_rw_flag, 2'b10);
    tick();
    rst = 1'b0;
    #1;
    check("t5_async_flag", mem_rw_flag, 2'b00);
    check("t5_async_done", d_done, 1'b0);
    check("t5_async_addr", mem_addr, 32'h0);
    run(2);
    check("t5_no_done", d_done_n, 0);
    rst = 1'b1;
    lat_fixed = 2;
    clear_logs();
    run(10);
    check("t5_regrant_addr", (gq.size() > 0) ? gq[0] : 32'hFFFF_FFFF, 32'h300);
    check("t5_regrant_flag", (gflag.size() > 0) ? gflag[0] : 2'b11, 2'b10);
    check("t5_done_once", d_done_n, 1);

`ifdef MEM_ARB_PERF_EN
    rst = 1'b0;
    run(2);
    rst = 1'b1;
    run(2);
    for (int k = 0; k < 3; k++) begin
      d_rw_flag = 2'b10; d_addr = 32'h500 + 32'(k);
      run(8);
    end
    for (int k = 0; k < 2; k++) begin
      i_rw_flag = 2'b01; i_addr = 32'h600 + 32'(k);
      run(8);
    end
    check("perf_d_grants_lit", perf_d_grants, 32'd3);
    check("perf_i_grants_lit", perf_i_grants, 32'd2);
    check("perf_i_wait_lit", perf_i_wait, 32'd2);
`endif

    // randomized traffic, random memory busy/latency and stray done pulses
    lat_fixed = 0; spurious_en = 1; rand_busy = 1; rand_req = 1;
    i_pend = 0; d_pend = 0;
    run(4000);
    rand_req = 0; rand_busy = 0; spurious_en = 0; mem_busy = 1'b0;
    run(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
